// File: rtl/serial_ctrl_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU sequencer.
package serial_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_LOADB = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational 1-bit ALU slice; subtraction inverts b here so the caller
// only seeds the carry with 1.
module serial_alu_bit
  import serial_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff  = (op == OP_SUB) ? ~b : b;
    result = 1'b0;
    cout   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = a ^ b_eff ^ cin;
        cout   = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_PASSB: result = b;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_op_sequencer.sv
// Sequences one bit-serial ALU operation (or a parallel load) on an external
// accumulator shift register and produces carry/zero flags.
module serial_op_sequencer
  import serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] acc_bits,
  output logic             acc_load_en,
  output logic             acc_write_en,
  output logic [WIDTH-1:0] acc_parallel_in,
  output logic             alu_result,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry_reg;
  logic             zero_acc;
  logic             slice_res;
  logic             slice_cout;
  logic             last_bit;

  serial_alu_bit u_alu_bit (
    .a      (acc_bits[bit_cnt]),
    .b      (b_reg[bit_cnt]),
    .cin    (carry_reg),
    .op     (op_reg),
    .result (slice_res),
    .cout   (slice_cout)
  );

  assign last_bit        = (bit_cnt == LAST_BIT);
  assign acc_parallel_in = b_reg;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    acc_load_en  = 1'b0;
    acc_write_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    alu_result   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (opcode)
            OP_LOADB: state_nxt = ST_LOAD;
            OP_NOP:   state_nxt = ST_DONE;
            default:  state_nxt = ST_SHIFT;
          endcase
        end
      end
      ST_LOAD: begin
        acc_load_en = 1'b1;
        busy        = 1'b1;
        state_nxt   = ST_DONE;
      end
      ST_SHIFT: begin
        // write_en must stay high for the whole op or the accumulator's bit index restarts
        acc_write_en = 1'b1;
        busy         = 1'b1;
        alu_result   = slice_res;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= OP_NOP;
      b_reg      <= '0;
      bit_cnt    <= '0;
      carry_reg  <= 1'b0;
      zero_acc   <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_reg    <= opcode;
            b_reg     <= operand_b;
            carry_reg <= (opcode == OP_SUB);
            zero_acc  <= 1'b1;
            bit_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          carry_flag <= 1'b0;
          zero_flag  <= (b_reg == '0);
        end
        ST_SHIFT: begin
          carry_reg <= slice_cout;
          zero_acc  <= zero_acc & ~slice_res;
          if (last_bit) begin
            // flags include the final bit, so take them straight from the slice
            carry_flag <= ((op_reg == OP_ADD) || (op_reg == OP_SUB)) ? slice_cout : 1'b0;
            zero_flag  <= zero_acc & ~slice_res;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_op_sequencer.sv
// Scoreboard bench for serial_op_sequencer driving a behavioural accumulator.
module tb_serial_op_sequencer;
  import serial_ctrl_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] acc_model;
  logic             acc_load_en;
  logic             acc_write_en;
  logic [WIDTH-1:0] acc_parallel_in;
  logic             alu_result;
  logic             busy;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;

  serial_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .opcode          (opcode),
    .operand_b       (operand_b),
    .acc_bits        (acc_model),
    .acc_load_en     (acc_load_en),
    .acc_write_en    (acc_write_en),
    .acc_parallel_in (acc_parallel_in),
    .alu_result      (alu_result),
    .busy            (busy),
    .done            (done),
    .carry_flag      (carry_flag),
    .zero_flag       (zero_flag)
  );

  always #5 clk = ~clk;

  // Accumulator: LSB-first serial writes, index restarts whenever write_en is low
  int acc_idx = 0;
  initial acc_model = '0;
  always @(posedge clk) begin
    if (acc_load_en) begin
      acc_model <= acc_parallel_in;
    end else if (acc_write_en) begin
      acc_model[acc_idx] <= alu_result;
    end
    if (acc_write_en) acc_idx <= acc_idx + 1;
    else              acc_idx <= 0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic             z;
    int               we;
    int               ld;
    int               lat;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  int we_cnt = 0;
  int ld_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      we_cnt = 0;
      ld_cnt = 0;
    end else begin
      we_cnt += int'(acc_write_en);
      ld_cnt += int'(acc_load_en);
      chk("busy_decode", {31'd0, busy}, {31'd0, acc_write_en | acc_load_en});
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_acc"},     {24'd0, acc_model}, {24'd0, e.acc});
          chk({e.name, "_carry"},   {31'd0, carry_flag}, {31'd0, e.c});
          chk({e.name, "_zero"},    {31'd0, zero_flag},  {31'd0, e.z});
          chk({e.name, "_we_cyc"},  we_cnt, e.we);
          chk({e.name, "_ld_cyc"},  ld_cnt, e.ld);
          chk({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
        end
        we_cnt = 0;
        ld_cnt = 0;
      end
    end
  end

  task automatic push_exp(input string nm, input logic [2:0] op,
                          input logic [WIDTH-1:0] eacc, input logic ec, input logic ez);
    exp_t e;
    e.name    = nm;
    e.acc     = eacc;
    e.c       = ec;
    e.z       = ez;
    e.we      = (op == OP_LOADB || op == OP_NOP) ? 0 : WIDTH;
    e.ld      = (op == OP_LOADB) ? 1 : 0;
    e.lat     = (op == OP_LOADB) ? 1 : (op == OP_NOP) ? 0 : WIDTH;
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Called #1 after a posedge while the DUT is idle
  task automatic issue(input string nm, input logic [2:0] op, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eacc, input logic ec, input logic ez);
    start = 1'b1; opcode = op; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = OP_NOP; operand_b = '0;
    push_exp(nm, op, eacc, ec, ez);
    wait_done(nm);
  endtask

  task automatic chk_all_zero(input string nm);
    @(negedge clk);
    chk({nm, "_busy"},   {31'd0, busy},         32'd0);
    chk({nm, "_done"},   {31'd0, done},         32'd0);
    chk({nm, "_ld"},     {31'd0, acc_load_en},  32'd0);
    chk({nm, "_we"},     {31'd0, acc_write_en}, 32'd0);
    chk({nm, "_pin"},    {24'd0, acc_parallel_in}, 32'd0);
    chk({nm, "_alu"},    {31'd0, alu_result},   32'd0);
    chk({nm, "_carry"},  {31'd0, carry_flag},   32'd0);
    chk({nm, "_zero"},   {31'd0, zero_flag},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; opcode = OP_NOP; operand_b = '0;
    repeat (2) @(posedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue("load_3c", OP_LOADB, 8'h3C, 8'h3C, 1'b0, 1'b0);
    issue("add_c5",  OP_ADD,   8'hC5, 8'h01, 1'b1, 1'b0);

    issue("load_10a", OP_LOADB, 8'h10, 8'h10, 1'b0, 1'b0);
    issue("sub_10",   OP_SUB,   8'h10, 8'h00, 1'b1, 1'b1);
    issue("nop",      OP_NOP,   8'h55, 8'h00, 1'b1, 1'b1);
    issue("load_10b", OP_LOADB, 8'h10, 8'h10, 1'b0, 1'b0);
    issue("sub_11",   OP_SUB,   8'h11, 8'hFF, 1'b0, 1'b0);

    issue("load_a5", OP_LOADB, 8'hA5, 8'hA5, 1'b0, 1'b0);
    issue("load_00", OP_LOADB, 8'h00, 8'h00, 1'b0, 1'b1);

    issue("load_f8", OP_LOADB, 8'hF8, 8'hF8, 1'b0, 1'b0);
    issue("add_f8",  OP_ADD,   8'hF8, 8'hF0, 1'b1, 1'b0);
    issue("and_3c",  OP_AND,   8'h3C, 8'h30, 1'b0, 1'b0);
    issue("or_3c",   OP_OR,    8'h3C, 8'h3C, 1'b0, 1'b0);
    issue("xor_3c",  OP_XOR,   8'h3C, 8'h00, 1'b0, 1'b1);
    issue("passb",   OP_PASSB, 8'h3C, 8'h3C, 1'b0, 1'b0);

    // start pulses during SHIFT and DONE must be dropped
    start = 1'b1; opcode = OP_ADD; operand_b = 8'hC4;
    @(posedge clk); #1;
    push_exp("add_ign", OP_ADD, 8'h00, 1'b1, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; opcode = OP_LOADB; operand_b = 8'hFF;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        seen = done;
      end
      if (!seen) chk("add_ign_done_timeout", 32'd0, 32'd1);
    end
    start = 1'b1; opcode = OP_LOADB; operand_b = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ignored_start_acc", {24'd0, acc_model}, 32'h00);
    chk("ignored_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // reset in the middle of a shift aborts without a done
    start = 1'b1; opcode = OP_ADD; operand_b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("mid_rst");
    repeat (4) @(posedge clk);
    #1;

    issue("load_7f",  OP_LOADB, 8'h7F, 8'h7F, 1'b0, 1'b0);
    issue("add_01",   OP_ADD,   8'h01, 8'h80, 1'b0, 1'b0);
    issue("add_80",   OP_ADD,   8'h80, 8'h00, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
